// File: rtl/boot_rom_loader.sv
// boot_rom_loader: walks a contiguous word range of the 32-bit boot ROM and streams the
// words out over valid/ready. The ROM has a 2-cycle registered read latency. A
// credit-limited issue pipe and a small output FIFO hide that latency, so downstream
// backpressure never loses a word.
// gclk carries the clk2x clock, which is the same clock domain as the ROM.
// Optional checksum feature: define BOOT_ROM_LOADER_CSUM_EN.
module boot_rom_loader #(
  parameter int unsigned ADDRMSB    = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 gclk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [ADDRMSB:0]     base_addr,
  input  logic [ADDRMSB+1:0]   num_words,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [ADDRMSB:0]     rom_addr,
  input  logic [31:0]          rom_dout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [ADDRMSB:0]     out_addr
`ifdef BOOT_ROM_LOADER_CSUM_EN
  ,
  input  logic [31:0]          csum_exp,
  output logic [31:0]          csum,
  output logic                 csum_ok
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDRMSB:0]     next_addr_q;
  logic [ADDRMSB+1:0]   remaining_q;
  logic                 v1_q, v2_q;
  logic [ADDRMSB:0]     a1_q, a2_q;
  logic [31:0]          fifo_data_q [FIFO_DEPTH];
  logic [ADDRMSB:0]     fifo_addr_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PW:0]          count_q;

  logic                 accept, stop, issue, push, pop, last_issue;
  logic [PW+1:0]        occ;

  // Handshakes, credit check and issue decision.
  always_comb begin
    accept     = (state_q == IDLE) && start;
    stop       = abort && ((state_q == FETCH) || (state_q == DRAIN));
    push       = v2_q;
    pop        = out_valid && out_ready;
    // Occupancy seen by the credit rule: a pop this cycle frees its slot immediately.
    occ        = (PW+2)'(count_q) + (PW+2)'(v1_q) + (PW+2)'(v2_q) - (PW+2)'(pop);
    issue      = (state_q == FETCH) && !abort && (remaining_q != '0) &&
                 (occ < (PW+2)'(FIFO_DEPTH));
    last_issue = issue && (remaining_q == (ADDRMSB+2)'(1));
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = (num_words == '0) ? DONE : FETCH;
      FETCH: begin
        if (abort) state_d = DONE;
        else if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort) begin
          state_d = DONE;
        end else if (!v1_q && !v2_q &&
                     ((count_q == '0) || ((count_q == (PW+1)'(1)) && pop))) begin
          state_d = DONE;
        end
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  // next_addr_q is held after the final issue so rom_addr keeps the last address read.
  assign rom_addr  = next_addr_q;
  assign out_valid = (count_q != '0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_addr  = fifo_addr_q[rd_ptr_q];

  // State register, address walker and remaining-word counter.
  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      next_addr_q <= '0;
      remaining_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && (num_words != '0)) begin
        next_addr_q <= base_addr;
        remaining_q <= num_words;
      end else if (issue) begin
        remaining_q <= remaining_q - (ADDRMSB+2)'(1);
        if (!last_issue) next_addr_q <= next_addr_q + (ADDRMSB+1)'(1);
      end
    end
  end

  // Two-stage in-flight pipe tracking the ROM read latency.
  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      a1_q <= '0;
      a2_q <= '0;
    end else if (stop) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= issue;
      a1_q <= next_addr_q;
      v2_q <= v1_q;
      a2_q <= a1_q;
    end
  end

  // Output FIFO: stage-2 pushes the returning ROM word; abort flushes it.
  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (stop) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= rom_dout;
        fifo_addr_q[wr_ptr_q] <= a2_q;
        wr_ptr_q              <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The credit rule makes a push into a full FIFO impossible.
  assert property (@(posedge gclk) disable iff (!rstn)
                   !(push && !pop && (count_q == (PW+1)'(FIFO_DEPTH))));

`ifdef BOOT_ROM_LOADER_CSUM_EN
  logic [31:0] csum_q, csum_exp_q;
  logic        csum_ok_q, aborted_q;

  // Running sum of accepted words; verdict latched during the done cycle.
  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      csum_q     <= '0;
      csum_exp_q <= '0;
      csum_ok_q  <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      if (accept) begin
        csum_q     <= '0;
        csum_exp_q <= csum_exp;
        aborted_q  <= 1'b0;
      end else begin
        if (pop)  csum_q    <= csum_q + out_data;
        if (stop) aborted_q <= 1'b1;
      end
      if (state_q == DONE) csum_ok_q <= (csum_q == csum_exp_q) && !aborted_q;
    end
  end

  assign csum    = csum_q;
  assign csum_ok = csum_ok_q;
`endif

endmodule

// File: tb/tb_boot_rom_loader.sv
// Self-checking bench for boot_rom_loader: a behavioural 2-cycle ROM, a queue of expected
// {addr, data} words built from the requested range, and randomized transfers.
module tb_boot_rom_loader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, abort, out_ready;
  logic [10:0] base_addr;
  logic [11:0] num_words;
  logic        busy, done, out_valid;
  logic [10:0] rom_addr, out_addr;
  logic [31:0] rom_dout, out_data;
  logic [31:0] csum_exp;
`ifdef BOOT_ROM_LOADER_CSUM_EN
  logic [31:0] csum;
  logic        csum_ok;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic rom_mode = 1'b0;  // 0: word = addr * 0x01010101, 1: every word is 1

  always #5 clk = ~clk;

  boot_rom_loader #(.ADDRMSB(10), .FIFO_DEPTH(4)) dut (
    .gclk      (clk),
    .rstn      (rstn),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr)
`ifdef BOOT_ROM_LOADER_CSUM_EN
    ,
    .csum_exp  (csum_exp),
    .csum      (csum),
    .csum_ok   (csum_ok)
`endif
  );

  function automatic logic [31:0] rom_fn(input logic [10:0] a);
    return rom_mode ? 32'h1 : 32'(a) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] model_sum(input logic [10:0] base, input logic [11:0] n);
    logic [31:0] s = '0;
    for (int i = 0; i < int'(n); i++) s += rom_fn(base + 11'(i));
    return s;
  endfunction

  // Behavioural ROM: data for the address presented in cycle k is visible in cycle k+2.
  logic [31:0] rom_r1, rom_r2;
  always @(posedge clk) begin
    rom_r1 <= rom_fn(rom_addr);
    rom_r2 <= rom_r1;
  end
  assign rom_dout = rom_r2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transfer. pat: 0 ready always high, 1 one-on/three-off, 2 random.
  // abort_after >= 0 aborts (with out_ready low) once that many words have been accepted.
  task automatic run(input logic [10:0] base, input logic [11:0] n, input int pat,
                     input int abort_after, input logic [31:0] cexp);
    logic [42:0] expq[$];
    logic [42:0] w, prev_word;
    logic [31:0] sum;
    logic [10:0] addr0;
    logic        aborted, prev_stall;
    int          acc, cyc, first_cyc, last_acc_cyc, done_cyc, budget;
    for (int i = 0; i < int'(n); i++) begin
      logic [10:0] a;
      a = base + 11'(i);
      expq.push_back({a, rom_fn(a)});
    end
    @(negedge clk);
    addr0     = rom_addr;
    start     = 1'b1;
    base_addr = base;
    num_words = n;
    csum_exp  = cexp;
    out_ready = (pat == 0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0; acc = 0; sum = '0; first_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
    aborted = 1'b0; prev_stall = 1'b0; prev_word = '0;
    budget = 20 * int'(n) + 40;
    // cyc counts clock edges since the edge that sampled start
    while (done_cyc < 0 && cyc < budget) begin
      abort = 1'b0;
      if (prev_stall) check("stall_hold", {out_valid, out_addr, out_data}, {1'b1, prev_word});
      if (aborted) check("abort_flush", 64'(out_valid), 64'(0));
      if (done) begin
        done_cyc = cyc;
        check("done_novalid", 64'(out_valid), 64'(0));
      end else begin
        check("busy", 64'(busy), 64'(1));
        if (abort_after >= 0 && acc == abort_after && !aborted) begin
          out_ready = 1'b0;
          abort     = 1'b1;
          aborted   = 1'b1;
        end else begin
          out_ready = (pat == 0) ? 1'b1 : (pat == 1) ? (cyc % 4 == 0) : 1'($urandom_range(0, 1));
        end
        if (out_valid && first_cyc < 0) first_cyc = cyc;
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            check("word_count", 64'(acc + 1), 64'(n));
          end else begin
            w = expq.pop_front();
            check("word", {out_addr, out_data}, w);
          end
          if (pat == 0) check("throughput", 64'(cyc), 64'(first_cyc + acc));
          sum += out_data;
          acc++;
          last_acc_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready && !abort;
        prev_word  = {out_addr, out_data};
      end
      if (done_cyc < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    abort = 1'b0;
    check("done_seen", 64'(done_cyc >= 0), 64'(1));
    if (!aborted) check("all_words", 64'(acc), 64'(n));
    if (n == 0) begin
      // DONE is entered on the edge that samples start; nothing is issued
      check("zero_done_lat", 64'(done_cyc), 64'(0));
      check("zero_addr_hold", 64'(rom_addr), 64'(addr0));
    end else if (pat == 0 && !aborted) begin
      check("first_lat", 64'(first_cyc), 64'(3));
      check("done_lat", 64'(done_cyc), 64'(last_acc_cyc + 1));
    end
    @(negedge clk);
    check("done_pulse", {busy, done, out_valid}, 64'(0));
`ifdef BOOT_ROM_LOADER_CSUM_EN
    check("csum", 64'(csum), 64'(sum));
    check("csum_ok", 64'(csum_ok), 64'((sum == cexp) && !aborted));
`endif
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    base_addr = '0; num_words = '0; csum_exp = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {busy, done, out_valid, rom_addr, out_data, out_addr}, 64'(0));
    rstn = 1'b1;

    run(11'h010, 12'd8,  0, -1, model_sum(11'h010, 12'd8));
    run(11'h000, 12'd16, 1, -1, 32'h1234);
    run(11'h7FE, 12'd4,  0, -1, model_sum(11'h7FE, 12'd4));
    run(11'h123, 12'd0,  0, -1, 32'h0);
    run(11'h040, 12'd32, 0, 5,  model_sum(11'h040, 12'd32));
    run(11'h050, 12'd3,  0, -1, model_sum(11'h050, 12'd3));

    for (int r = 0; r < 12; r++) begin
      logic [10:0] b;
      logic [11:0] n;
      int          p, ab;
      b  = 11'($urandom);
      n  = 12'($urandom_range(0, 24));
      p  = int'($urandom_range(0, 2));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(n))) : -1;
      run(b, n, p, ab, ($urandom_range(0, 1) == 1) ? model_sum(b, n) : $urandom);
    end

    // Reset in the middle of a stalled transfer
    @(negedge clk);
    start = 1'b1; base_addr = 11'h200; num_words = 12'd32; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("reset_mid", {busy, done, out_valid, rom_addr, out_data, out_addr}, 64'(0));
`ifdef BOOT_ROM_LOADER_CSUM_EN
    check("reset_mid_csum", {csum_ok, csum}, 64'(0));
`endif
    @(negedge clk);
    rstn = 1'b1;

`ifdef BOOT_ROM_LOADER_CSUM_EN
    rom_mode = 1'b1;
    run(11'h300, 12'd4, 0, -1, 32'd4);
    run(11'h300, 12'd4, 0, -1, 32'd5);
    rom_mode = 1'b0;
`endif
    run(11'h3F0, 12'd20, 2, -1, model_sum(11'h3F0, 12'd20));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
